uart_deframe: RTL and testbench
===============================

Name: uart_deframe

Overview:
- Receive-side UART frame splitter. Sits after the RX shift register.
- Takes one complete serial frame, already in parallel form, whenever `recieved_flag` is high.
- Registers the start, data, parity and stop fields separately, checks parity and framing, and pulses `done_flag` one cycle later.
- Purely field extraction and checking; no oversampling or shifting.

Parameters:
- DATA_BITS, 8, number of data bits per frame (legal 5..9).
- PARITY_EN, 1, 1 = frame carries one parity bit, 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity (parity bit equals XOR-reduce of data), 1 = odd parity (parity bit equals inverted XOR-reduce).
- STOP_BITS, 1, number of stop bits (legal 1 or 2).
- FRAME_W (localparam), 1+DATA_BITS+PARITY_EN+STOP_BITS, frame width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_parll  in  FRAME_W  parallel frame. Bit 0 = start bit; bits [DATA_BITS:1] = data, LSB first on the line, so bit 1 = data[0]; bit DATA_BITS+1 = parity (if PARITY_EN); top STOP_BITS bits = stop bit(s).
- recieved_flag  in  1  frame-valid qualifier, sampled each rising edge.
- raw_data  out  DATA_BITS  extracted data byte.
- start_bit  out  1  extracted start bit.
- parity_bit  out  1  extracted parity bit (0 when PARITY_EN=0).
- stop_bit  out  1  AND of all extracted stop bits.
- done_flag  out  1  one-cycle-per-capture valid strobe.
- parity_err  out  1  parity mismatch on captured frame.
- frame_err  out  1  start bit not 0, or any stop bit not 1.
- err_count  out  8  saturating error counter. Present only with DEFRAME_ERR_CNT_EN.

Behaviour:
- Reset (rst=1 at rising edge), clock-synchronous:
  - raw_data=0, start_bit=0, parity_bit=0, stop_bit=1.
  - done_flag=0, parity_err=0, frame_err=0, err_count=0.
  - Reset has priority over recieved_flag.
  - Reset mid-stream: a frame presented in the same cycle as rst is discarded.
- Capture:
  - On each rising edge with rst=0 and recieved_flag=1, all field outputs and error flags load from data_parll.
  - done_flag=1 in the following cycle. Latency is exactly 1 clock.
- Level-qualified: recieved_flag held high for N consecutive cycles means N captures and N consecutive done_flag cycles. Each cycle uses the current data_parll; no edge detection.
- recieved_flag=0: done_flag=0. Field outputs and error flags hold their last captured values.
- Parity check:
  - expected = XOR(data) XOR PARITY_ODD.
  - parity_err = (parity_bit != expected).
  - PARITY_EN=0: parity_bit=0 and parity_err=0 always.
- Frame check:
  - frame_err = start bit is 1, OR any stop bit is 0.
  - With STOP_BITS=2, both stop bits are checked.
- All outputs are registered; no combinational path from input to output.
- Unused or illegal parameter values are not supported; flag them with an elaboration-time error.

Optional Feature:
- Macro DEFRAME_ERR_CNT_EN.
- When defined:
  - An 8-bit err_count port exists.
  - Increments by 1 on each capture where parity_err OR frame_err is computed true.
  - Saturates at 255. Cleared only by rst.
  - Updates in the same cycle done_flag rises.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan (DATA_BITS=8, PARITY_EN=1, STOP_BITS=1, FRAME_W=11):
- Reset: rst=1 for 2 cycles with recieved_flag=1, data_parll=11'h7FF -> raw_data=00, start_bit=0, stop_bit=1, done_flag=0, all errors 0.
- Valid frame: recieved_flag=1, data_parll=11'h54A (data A5, parity 0) for one cycle -> next cycle raw_data=A5, start=0, parity=0, stop=1, done_flag=1, parity_err=0, frame_err=0; then recieved_flag=0 -> done_flag=0, fields hold.
- Parity error: data_parll=11'h678 (data 3C, parity 1) -> raw_data=3C, parity_bit=1, parity_err=1, frame_err=0, err_count increments.
- Boundary data, back-to-back with recieved_flag held high:
  - 11'h400 -> raw_data=00, no errors.
  - 11'h5FE on the next cycle -> raw_data=FF, no errors.
  - done_flag high both cycles.
- Framing error:
  - 11'h54B (start=1) -> frame_err=1.
  - 11'h14A (stop=0) -> stop_bit=0, frame_err=1.
  - With 300 error frames and DEFRAME_ERR_CNT_EN defined, err_count saturates at 255.
- Reset mid-operation: rst asserted together with recieved_flag=1 and a valid frame -> frame discarded, outputs show reset values, done_flag=0.

Source files
------------

// File: rtl/uart_deframe_if.sv
// -----------------------------------------------------------------------------
// uart_deframe_if
// Bundle between the RX shift register (master) and the frame splitter
// (slave). The parallel frame and its valid qualifier flow master -> slave;
// the extracted fields, the done strobe and the error flags flow back.
//
// Signals:
//   data_parll    FRAME_W  parallel frame (bit 0 = start, top bits = stop)
//   recieved_flag 1        frame-valid qualifier
//   raw_data      DATA_BITS extracted data
//   start_bit     1        extracted start bit
//   parity_bit    1        extracted parity bit (0 without parity)
//   stop_bit      1        AND of all stop bits
//   done_flag     1        one-cycle strobe per capture
//   parity_err    1        parity mismatch on captured frame
//   frame_err     1        start bit 1 or any stop bit 0
//   err_count     8        saturating error count (only with DEFRAME_ERR_CNT_EN)
//
// Optional feature macro: DEFRAME_ERR_CNT_EN
// -----------------------------------------------------------------------------
interface uart_deframe_if #(
    parameter int DATA_BITS = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
);
    localparam int FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS;

    logic [FRAME_W-1:0]   data_parll;
    logic                 recieved_flag;
    logic [DATA_BITS-1:0] raw_data;
    logic                 start_bit;
    logic                 parity_bit;
    logic                 stop_bit;
    logic                 done_flag;
    logic                 parity_err;
    logic                 frame_err;
`ifdef DEFRAME_ERR_CNT_EN
    logic [7:0]           err_count;
`endif

    // Producer side: the RX shift register.
    modport master (
        output data_parll,
        output recieved_flag,
        input  raw_data,
        input  start_bit,
        input  parity_bit,
        input  stop_bit,
        input  done_flag,
        input  parity_err,
`ifdef DEFRAME_ERR_CNT_EN
        input  err_count,
`endif
        input  frame_err
    );

    // Consumer side: the frame splitter.
    modport slave (
        input  data_parll,
        input  recieved_flag,
        output raw_data,
        output start_bit,
        output parity_bit,
        output stop_bit,
        output done_flag,
        output parity_err,
`ifdef DEFRAME_ERR_CNT_EN
        output err_count,
`endif
        output frame_err
    );
endinterface

// File: rtl/uart_deframe.sv
// -----------------------------------------------------------------------------
// uart_deframe
// Receive-side UART frame splitter. Whenever recieved_flag is high at a rising
// clock edge the parallel frame is split into start / data / parity / stop
// fields, parity and framing are checked, and done_flag rises in the next
// cycle. Capture is level-qualified: every qualified cycle is a capture.
// All outputs come straight from registers.
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset (wins over recieved_flag)
//   bus  slave modport of uart_deframe_if (frame in, fields/flags out)
//
// Parameters: DATA_BITS (5..9), PARITY_EN (0/1), PARITY_ODD (0/1),
//             STOP_BITS (1/2). The interface must be built with the same
//             DATA_BITS / PARITY_EN / STOP_BITS.
//
// Optional feature macro: DEFRAME_ERR_CNT_EN adds an 8-bit saturating error
// counter (err_count), cleared only by rst.
// -----------------------------------------------------------------------------
module uart_deframe #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic             clk,
    input  logic             rst,
    uart_deframe_if.slave    bus
);
    localparam int FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS;

    // ---------------------------------------------------------------------
    // Elaboration-time parameter legality checks
    // ---------------------------------------------------------------------
    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_deframe: DATA_BITS must be 5..9");
        end
        if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
            $error("uart_deframe: PARITY_EN must be 0 or 1");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
            $error("uart_deframe: PARITY_ODD must be 0 or 1");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_deframe: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // Expected parity bit for a data word: even parity makes the parity bit
    // equal to the XOR of the data, odd parity inverts it.
    function automatic logic parity_expect(input logic [DATA_BITS-1:0] data);
        return (^data) ^ 1'(PARITY_ODD);
    endfunction

    // ---------------------------------------------------------------------
    // Field extraction (combinational, feeds the _d side only)
    // ---------------------------------------------------------------------
    logic [DATA_BITS-1:0] data_field_s;
    logic                 start_field_s;
    logic [STOP_BITS-1:0] stop_field_s;
    logic                 stop_all_s;
    logic                 parity_field_s;
    logic                 parity_err_s;
    logic                 frame_err_s;

    assign start_field_s = bus.data_parll[0];
    assign data_field_s  = bus.data_parll[DATA_BITS:1];
    // Stop bits always occupy the top of the frame regardless of parity.
    assign stop_field_s  = bus.data_parll[FRAME_W-1 -: STOP_BITS];
    assign stop_all_s    = &stop_field_s;
    assign frame_err_s   = start_field_s | ~stop_all_s;

    generate
        if (PARITY_EN != 0) begin : g_parity
            assign parity_field_s = bus.data_parll[DATA_BITS+1];
            assign parity_err_s   = (parity_field_s != parity_expect(data_field_s));
        end else begin : g_no_parity
            // Without a parity bit the outputs are tied low.
            assign parity_field_s = 1'b0;
            assign parity_err_s   = 1'b0;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Output registers and their next-state values
    // ---------------------------------------------------------------------
    logic [DATA_BITS-1:0] raw_data_d,   raw_data_q;
    logic                 start_bit_d,  start_bit_q;
    logic                 parity_bit_d, parity_bit_q;
    logic                 stop_bit_d,   stop_bit_q;
    logic                 done_flag_d,  done_flag_q;
    logic                 parity_err_d, parity_err_q;
    logic                 frame_err_d,  frame_err_q;

    // Next-state for fields/flags: load on capture, otherwise hold.
    always_comb begin
        raw_data_d   = raw_data_q;
        start_bit_d  = start_bit_q;
        parity_bit_d = parity_bit_q;
        stop_bit_d   = stop_bit_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        done_flag_d  = 1'b0;
        if (bus.recieved_flag) begin
            raw_data_d   = data_field_s;
            start_bit_d  = start_field_s;
            parity_bit_d = parity_field_s;
            stop_bit_d   = stop_all_s;
            parity_err_d = parity_err_s;
            frame_err_d  = frame_err_s;
            done_flag_d  = 1'b1;
        end else begin
            done_flag_d  = 1'b0;
        end
    end

    // Field/flag registers; a frame presented while rst is high is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw_data_q   <= '0;
            start_bit_q  <= 1'b0;
            parity_bit_q <= 1'b0;
            stop_bit_q   <= 1'b1;
            done_flag_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            raw_data_q   <= raw_data_d;
            start_bit_q  <= start_bit_d;
            parity_bit_q <= parity_bit_d;
            stop_bit_q   <= stop_bit_d;
            done_flag_q  <= done_flag_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.raw_data   = raw_data_q;
    assign bus.start_bit  = start_bit_q;
    assign bus.parity_bit = parity_bit_q;
    assign bus.stop_bit   = stop_bit_q;
    assign bus.done_flag  = done_flag_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;

`ifdef DEFRAME_ERR_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating error counter; counts captures whose computed check fails,
    // so it moves in the same cycle done_flag rises.
    // ---------------------------------------------------------------------
    logic [7:0] err_count_d, err_count_q;

    // Next-state for the error counter: +1 per erroneous capture, stop at 255.
    always_comb begin
        err_count_d = err_count_q;
        if (bus.recieved_flag && (parity_err_s || frame_err_s) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // Error counter register, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q <= 8'd0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign bus.err_count = err_count_q;
`endif

endmodule

// File: tb/tb_uart_deframe.sv
// -----------------------------------------------------------------------------
// tb_uart_deframe
// Self-checking bench for uart_deframe with DATA_BITS=8, PARITY_EN=1,
// PARITY_ODD=0, STOP_BITS=1 (11-bit frames). A reference model computes the
// expected fields with integer shifts and a population count, one step per
// clock; directed frames are followed by a randomized stream.
// err_count is checked when DEFRAME_ERR_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_deframe;
    logic clk;
    logic rst;

    uart_deframe_if #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) bus ();

    uart_deframe #(
        .DATA_BITS (8),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .STOP_BITS (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model state (what the outputs must show after each edge).
    int exp_data;
    int exp_start;
    int exp_par;
    int exp_stop;
    int exp_done;
    int exp_perr;
    int exp_ferr;
    int exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare everything.
    task automatic step(input logic r, input logic f, input logic [10:0] fr);
        int fi;
        int d;
        int p;
        int s;
        int st;
        rst               = r;
        bus.recieved_flag = f;
        bus.data_parll    = fr;
        @(posedge clk);
        fi = int'(fr);
        if (r) begin
            exp_data = 0; exp_start = 0; exp_par = 0; exp_stop = 1;
            exp_done = 0; exp_perr = 0; exp_ferr = 0; exp_cnt = 0;
        end else if (f) begin
            st = fi % 2;
            d  = (fi / 2) % 256;
            p  = (fi / 512) % 2;
            s  = (fi / 1024) % 2;
            exp_data  = d;
            exp_start = st;
            exp_par   = p;
            exp_stop  = s;
            exp_done  = 1;
            // Even parity: parity bit must match the parity of the data's 1-count.
            exp_perr  = (p != ($countones(d) % 2)) ? 1 : 0;
            exp_ferr  = (st == 1 || s == 0) ? 1 : 0;
            if ((exp_perr == 1 || exp_ferr == 1) && exp_cnt < 255) exp_cnt++;
        end else begin
            exp_done = 0;
        end
        #1;
        chk("raw_data",   32'(bus.raw_data),   32'(exp_data));
        chk("start_bit",  32'(bus.start_bit),  32'(exp_start));
        chk("parity_bit", 32'(bus.parity_bit), 32'(exp_par));
        chk("stop_bit",   32'(bus.stop_bit),   32'(exp_stop));
        chk("done_flag",  32'(bus.done_flag),  32'(exp_done));
        chk("parity_err", 32'(bus.parity_err), 32'(exp_perr));
        chk("frame_err",  32'(bus.frame_err),  32'(exp_ferr));
`ifdef DEFRAME_ERR_CNT_EN
        chk("err_count",  32'(bus.err_count),  32'(exp_cnt));
`endif
    endtask

    initial begin
        logic [10:0] fr;
        total = 0;
        bad   = 0;
        exp_data = 0; exp_start = 0; exp_par = 0; exp_stop = 1;
        exp_done = 0; exp_perr = 0; exp_ferr = 0; exp_cnt = 0;
        rst               = 1'b1;
        bus.recieved_flag = 1'b1;
        bus.data_parll    = 11'h7FF;

        // Reset wins over a qualified frame.
        step(1'b1, 1'b1, 11'h7FF);
        step(1'b1, 1'b1, 11'h7FF);
        chk("reset_raw_literal", 32'(bus.raw_data), 32'h0000_0000);

        // Valid frame, then hold with flag low.
        step(1'b0, 1'b1, 11'h54A);
        chk("valid_a5_literal", 32'(bus.raw_data), 32'h0000_00A5);
        step(1'b0, 1'b0, 11'h000);
        step(1'b0, 1'b0, 11'h7FF);

        // Parity error.
        step(1'b0, 1'b1, 11'h678);
        chk("perr_literal", 32'(bus.parity_err), 32'h0000_0001);
        step(1'b0, 1'b0, 11'h000);

        // Boundary data back-to-back.
        step(1'b0, 1'b1, 11'h400);
        step(1'b0, 1'b1, 11'h5FE);
        chk("ff_literal", 32'(bus.raw_data), 32'h0000_00FF);

        // Framing errors.
        step(1'b0, 1'b1, 11'h54B);
        step(1'b0, 1'b1, 11'h14A);
        chk("stop0_literal", 32'(bus.frame_err), 32'h0000_0001);

        // Reset mid-stream discards the concurrent frame.
        step(1'b0, 1'b1, 11'h54A);
        step(1'b1, 1'b1, 11'h54A);
        step(1'b0, 1'b0, 11'h54A);

        // Randomized stream with occasional reset.
        for (int i = 0; i < 300; i++) begin
            fr = 11'($urandom_range(0, 2047));
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, fr);
        end

        // Long run of error frames to drive the counter into saturation.
        step(1'b1, 1'b0, 11'h000);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, (i % 2 == 0) ? 11'h54B : 11'h678);
        end
`ifdef DEFRAME_ERR_CNT_EN
        chk("err_count_sat", 32'(bus.err_count), 32'd255);
`endif
        step(1'b0, 1'b0, 11'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
